// File: rtl/cpu_clock_controller.sv
// Generates the divided CPU clock from clkf. It supports free-run, single-step and halt modes,
// and counts the rising edges of the CPU clock.
module cpu_clock_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clkf,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic             halt_req,
   input  logic             cfg_load,
   input  logic [3:0]       div_sel,
   output logic             clk,
   output logic             clk_rise,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic               r_clk;
   logic               r_clk_rise;
   logic               r_running;
   logic               r_halted;
   logic               r_step_q;
   logic [3:0]         r_cnt;
   logic [3:0]         r_div;
   logic [CNT_W-1:0]   r_cycle_count;

   logic               w_step_edge;
   logic               w_due;
   logic               w_stop;
   logic               w_toggle;
   logic               w_clk_next;
   logic [3:0]         w_cnt_next;

   assign w_step_edge = step & ~r_step_q;
   assign w_due       = (r_cnt == r_div);
   // Stopping is only legal at the end of a high phase, so a started low phase always completes.
   assign w_stop      = w_due & r_clk & (halt_req | ~start);

   // State register
   always_ff @(posedge clkf) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_RUN;
            end else if (w_step_edge) begin
               w_next_state = S_STEP;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_stop && halt_req) begin
               w_next_state = S_HALT;
            end else if (w_stop) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_RUN;
            end
         end
         S_STEP: begin
            if (w_due && !r_clk) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_STEP;
            end
         end
         S_HALT: begin
            if (!start) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_HALT;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output/datapath decode
   always_comb begin
      w_toggle   = 1'b0;
      w_cnt_next = 4'd0;
      w_clk_next = 1'b1;
      case (r_state)
         S_RUN: begin
            w_toggle   = w_due & ~w_stop;
            w_cnt_next = w_due ? 4'd0 : r_cnt + 4'd1;
            w_clk_next = w_toggle ? ~r_clk : r_clk;
         end
         S_STEP: begin
            w_toggle   = w_due;
            w_cnt_next = w_due ? 4'd0 : r_cnt + 4'd1;
            w_clk_next = w_toggle ? ~r_clk : r_clk;
         end
         S_IDLE: begin
            w_toggle   = 1'b0;
            w_cnt_next = 4'd0;
            w_clk_next = 1'b1;
         end
         S_HALT: begin
            w_toggle   = 1'b0;
            w_cnt_next = 4'd0;
            w_clk_next = 1'b1;
         end
         default: begin
            w_toggle   = 1'b0;
            w_cnt_next = 4'd0;
            w_clk_next = 1'b1;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clkf) begin
      if (rst) begin
         r_clk         <= 1'b1;
         r_clk_rise    <= 1'b0;
         r_running     <= 1'b0;
         r_halted      <= 1'b0;
         r_step_q      <= 1'b0;
         r_cnt         <= 4'd0;
         r_div         <= 4'd3;
         r_cycle_count <= '0;
      end else begin
         r_clk      <= w_clk_next;
         r_cnt      <= w_cnt_next;
         r_step_q   <= step;
         r_running  <= (w_next_state == S_RUN);
         r_halted   <= (w_next_state == S_HALT);
         r_clk_rise <= w_toggle & ~r_clk;
         if (w_toggle && !r_clk) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
         end else begin
            r_cycle_count <= r_cycle_count;
         end
         if (cfg_load && (r_state == S_IDLE || r_state == S_HALT)) begin
            r_div <= div_sel;
         end else begin
            r_div <= r_div;
         end
      end
   end

   assign clk         = r_clk;
   assign clk_rise    = r_clk_rise;
   assign running     = r_running;
   assign halted      = r_halted;
   assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller: expected values are queued before each
// stimulus window and popped when the DUT outputs are sampled.
module tb_cpu_clock_controller;

   logic        clkf = 1'b0;
   logic        rst, start, step, halt_req, cfg_load;
   logic [3:0]  div_sel;
   logic        clk16, rise16, run16, halt16;
   logic [15:0] cc16;
   logic        clk4, rise4, run4, halt4;
   logic [3:0]  cc4;

   cpu_clock_controller #(.CNT_W(16)) dut16 (
      .clkf(clkf), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
      .cfg_load(cfg_load), .div_sel(div_sel), .clk(clk16), .clk_rise(rise16),
      .running(run16), .halted(halt16), .cycle_count(cc16));

   cpu_clock_controller #(.CNT_W(4)) dut4 (
      .clkf(clkf), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
      .cfg_load(cfg_load), .div_sel(div_sel), .clk(clk4), .clk_rise(rise4),
      .running(run4), .halted(halt4), .cycle_count(cc4));

   always #5 clkf = ~clkf;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          lows, rises, bad;
   logic [15:0] prev_cc;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      e = sb.pop_front();
      vectors++;
      assert (obs === e.val) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
   endtask

   // One clkf cycle; sample 1 time unit after the edge and gather statistics.
   task automatic tick();
      logic rst_at_edge;
      rst_at_edge = rst;
      @(posedge clkf);
      #1;
      if (clk16 == 1'b0) lows++;
      if (rise16) rises++;
      if (!rst_at_edge && ((cc16 != prev_cc) !== rise16)) bad++;
      prev_cc = cc16;
   endtask

   task automatic ticks_until_low(input int bound, output int n);
      n = 0;
      while (clk16 && n < bound) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int first;
      logic [3:0] prev4;
      logic wrapped;
      rst = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0;
      cfg_load = 1'b0; div_sel = 4'd0; prev_cc = 16'd0; bad = 0;
      tick(); tick();
      push("rst_clk", 32'd1);      chk({31'd0, clk16});
      push("rst_rise", 32'd0);     chk({31'd0, rise16});
      push("rst_running", 32'd0);  chk({31'd0, run16});
      push("rst_halted", 32'd0);   chk({31'd0, halt16});
      push("rst_count", 32'd0);    chk({16'd0, cc16});
      rst = 1'b0;

      // Free run at the reset divide of 3
      start = 1'b1;
      tick();
      push("run_enter", 32'd1);    chk({31'd0, run16});
      lows = 0; rises = 0; first = -1;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (first < 0 && clk16 == 1'b0) first = i;
      end
      push("first_fall", 32'd4);   chk(first);
      push("run64_lows", 32'd32);  chk(lows);
      push("run64_rises", 32'd8);  chk(rises);
      push("run64_count", 32'd8);  chk({16'd0, cc16});

      // Drop start: stop at the end of the high phase without a low glitch
      start = 1'b0; lows = 0; n = 0;
      while (run16 && n < 20) begin
         tick();
         n++;
      end
      push("stop_ticks", 32'd4);   chk(n);
      push("stop_lows", 32'd0);    chk(lows);
      push("stop_clk", 32'd1);     chk({31'd0, clk16});

      // Divide 0 loaded in IDLE; a load during RUN is ignored
      cfg_load = 1'b1; div_sel = 4'd0;
      tick();
      cfg_load = 1'b0; start = 1'b1;
      tick();
      lows = 0; rises = 0;
      repeat (20) tick();
      push("div0_lows", 32'd10);   chk(lows);
      push("div0_rises", 32'd10);  chk(rises);
      cfg_load = 1'b1; div_sel = 4'd7; lows = 0; rises = 0;
      repeat (20) tick();
      cfg_load = 1'b0;
      push("ign_lows", 32'd10);    chk(lows);
      push("ign_rises", 32'd10);   chk(rises);
      push("div0_count", 32'd28);  chk({16'd0, cc16});
      push("c4_count", 32'd12);    chk({28'd0, cc4});

      // Halt requested during the low phase
      tick();
      push("pre_halt_low", 32'd0); chk({31'd0, clk16});
      halt_req = 1'b1;
      tick();
      push("halt_rise_clk", 32'd1); chk({31'd0, clk16});
      push("halt_rise_pulse", 32'd1); chk({31'd0, rise16});
      push("halt_not_yet", 32'd0); chk({31'd0, halt16});
      tick();
      push("halted", 32'd1);       chk({31'd0, halt16});
      push("halt_running", 32'd0); chk({31'd0, run16});
      cfg_load = 1'b1; div_sel = 4'd3; lows = 0;
      repeat (5) tick();
      cfg_load = 1'b0;
      push("halt_lows", 32'd0);    chk(lows);
      push("halt_hold", 32'd1);    chk({31'd0, halt16});
      push("halt_count", 32'd29);  chk({16'd0, cc16});
      start = 1'b0;
      tick();
      push("halt_exit", 32'd0);    chk({31'd0, halt16});
      halt_req = 1'b0;

      // Single step with step held high
      step = 1'b1; lows = 0; rises = 0;
      repeat (50) tick();
      push("step_lows", 32'd4);    chk(lows);
      push("step_rises", 32'd1);   chk(rises);
      push("step_count", 32'd30);  chk({16'd0, cc16});
      push("step_idle", 32'd0);    chk({31'd0, run16});
      step = 1'b0;
      tick();
      step = 1'b1; halt_req = 1'b1; lows = 0; rises = 0;
      repeat (20) tick();
      push("step2_lows", 32'd4);   chk(lows);
      push("step2_count", 32'd31); chk({16'd0, cc16});
      push("step2_halted", 32'd0); chk({31'd0, halt16});
      step = 1'b0; halt_req = 1'b0;

      // Reset in the middle of a low phase with divide 5
      cfg_load = 1'b1; div_sel = 4'd5;
      tick();
      cfg_load = 1'b0; start = 1'b1;
      ticks_until_low(20, n);
      push("div5_fall", 32'd7);    chk(n);
      tick();
      rst = 1'b1;
      tick();
      push("mid_rst_clk", 32'd1);  chk({31'd0, clk16});
      push("mid_rst_count", 32'd0); chk({16'd0, cc16});
      push("mid_rst_run", 32'd0);  chk({31'd0, run16});
      push("mid_rst_c4", 32'd0);   chk({28'd0, cc4});
      rst = 1'b0;
      ticks_until_low(20, n);
      push("rst_div3_fall", 32'd5); chk(n);
      rst = 1'b1; start = 1'b0;
      tick();
      rst = 1'b0;

      // 16 rises on the 4-bit counter
      cfg_load = 1'b1; div_sel = 4'd0;
      tick();
      cfg_load = 1'b0; start = 1'b1;
      tick();
      wrapped = 1'b0; prev4 = cc4;
      repeat (32) begin
         tick();
         if (prev4 == 4'd15 && cc4 == 4'd0) wrapped = 1'b1;
         prev4 = cc4;
      end
      push("wrap_seen", 32'd1);    chk({31'd0, wrapped});
      push("wrap_c4", 32'd0);      chk({28'd0, cc4});
      push("wrap_c16", 32'd16);    chk({16'd0, cc16});
      push("rise_vs_count", 32'd0); chk(bad);
      start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
